// File: rtl/pll_phase_sequencer.sv
// Drives the ECP5 EHXPLLL dynamic phase-shift port (PHASESEL/PHASEDIR/PHASESTEP)
// and holds the downstream reset until PLL lock has been stable for a while.
module pll_phase_sequencer #(
  parameter int SETUP_CYC       = 4,
  parameter int STEP_LOW_CYC    = 4,
  parameter int STEP_GAP_CYC    = 8,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int CNT_W           = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             pll_locked_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_sel_i,
  input  logic             req_dir_i,
  input  logic [CNT_W-1:0] req_steps_i,
  output logic [1:0]       pll_phasesel_o,
  output logic             pll_phasedir_o,
  output logic             pll_phasestep_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             abort_o,
  output logic [CNT_W-1:0] steps_issued_o,
  output logic             rst_out_o
);

  localparam int MAX_AB = (SETUP_CYC > STEP_LOW_CYC) ? SETUP_CYC : STEP_LOW_CYC;
  localparam int MAXC   = (MAX_AB > STEP_GAP_CYC) ? MAX_AB : STEP_GAP_CYC;
  localparam int CYC_W  = $clog2(MAXC + 1);
  localparam int STB_W  = $clog2(LOCK_STABLE_CYC + 1);

  typedef enum logic [2:0] {
    LOCK_WAIT, IDLE, SETUP, PULSE_LO, PULSE_HI, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic [STB_W-1:0]   stb_q, stb_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic [1:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               abort_q, abort_d;
  logic               rst_q, rst_d;
  logic               lock_s;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    stb_d   = '0;
    cyc_d   = cyc_q + CYC_W'(1);
    rem_d   = rem_q;
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    abort_d = abort_q;
    rst_d   = rst_q;
    case (state_q)
      LOCK_WAIT: begin
        if (lock_s) begin
          if (stb_q == STB_W'(LOCK_STABLE_CYC - 1)) begin
            state_d = IDLE;
            rst_d   = 1'b0;
            stb_d   = stb_q;
          end else begin
            stb_d = stb_q + STB_W'(1);
          end
        end
      end
      IDLE: begin
        if (!lock_s) begin
          state_d = LOCK_WAIT;
          rst_d   = 1'b1;
        end else if (req_valid_i) begin
          sel_d   = req_sel_i;
          dir_d   = req_dir_i;
          rem_d   = req_steps_i;
          steps_d = '0;
          abort_d = 1'b0;
          cyc_d   = '0;
          state_d = (req_steps_i == '0) ? DONE : SETUP;
        end
      end
      SETUP, PULSE_LO, PULSE_HI: begin
        // Lock loss aborts the sequence; an unfinished low pulse is not counted.
        if (!lock_s) begin
          state_d = DONE;
          abort_d = 1'b1;
          rst_d   = 1'b1;
        end else if (state_q == SETUP) begin
          if (cyc_q == CYC_W'(SETUP_CYC - 1)) begin
            state_d = PULSE_LO;
            cyc_d   = '0;
          end
        end else if (state_q == PULSE_LO) begin
          if (cyc_q == CYC_W'(STEP_LOW_CYC - 1)) begin
            state_d = PULSE_HI;
            cyc_d   = '0;
            steps_d = steps_q + CNT_W'(1);
            rem_d   = rem_q - CNT_W'(1);
          end
        end else begin
          if (cyc_q == CYC_W'(STEP_GAP_CYC - 1)) begin
            cyc_d   = '0;
            state_d = (rem_q != '0) ? PULSE_LO : DONE;
          end
        end
      end
      DONE: begin
        if (abort_q || !lock_s) begin
          state_d = LOCK_WAIT;
          rst_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = LOCK_WAIT;
        rst_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= LOCK_WAIT;
      sync_q  <= '0;
      stb_q   <= '0;
      cyc_q   <= '0;
      rem_q   <= '0;
      steps_q <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b1;
      abort_q <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], pll_locked_i};
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      rem_q   <= rem_d;
      steps_q <= steps_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      abort_q <= abort_d;
      rst_q   <= rst_d;
    end
  end

  // Lock loss releases PHASESTEP in the same cycle it is seen.
  assign pll_phasestep_o = !((state_q == PULSE_LO) && lock_s);
  assign req_ready_o     = (state_q == IDLE) && lock_s;
  assign busy_o          = (state_q == SETUP) || (state_q == PULSE_LO) || (state_q == PULSE_HI);
  assign done_o          = (state_q == DONE);
  assign abort_o         = (state_q == DONE) && abort_q;
  assign pll_phasesel_o  = sel_q;
  assign pll_phasedir_o  = dir_q;
  assign steps_issued_o  = steps_q;
  assign rst_out_o       = rst_q;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Bench for pll_phase_sequencer: vector table, random requests against an
// arithmetic timing model, and lock-loss / reset corner sequences.
module tb_pll_phase_sequencer;
  localparam int CNT_W = 8;
  localparam int SETUP = 4;
  localparam int LO    = 4;
  localparam int GAP   = 8;
  localparam int PER   = LO + GAP;
  localparam int LSC   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pll_locked = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_sel = '0;
  logic             req_dir = 1'b0;
  logic [CNT_W-1:0] req_steps = '0;
  logic [1:0]       phasesel;
  logic             phasedir, phasestep, busy, done, abort, rst_out;
  logic [CNT_W-1:0] steps_issued;

  int checks = 0;
  int failures = 0;

  pll_phase_sequencer #(
    .SETUP_CYC(SETUP), .STEP_LOW_CYC(LO), .STEP_GAP_CYC(GAP),
    .LOCK_STABLE_CYC(LSC), .CNT_W(CNT_W)
  ) dut (
    .clock_i(clk), .reset_i(reset), .pll_locked_i(pll_locked),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sel_i(req_sel), .req_dir_i(req_dir), .req_steps_i(req_steps),
    .pll_phasesel_o(phasesel), .pll_phasedir_o(phasedir), .pll_phasestep_o(phasestep),
    .busy_o(busy), .done_o(done), .abort_o(abort),
    .steps_issued_o(steps_issued), .rst_out_o(rst_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    int         n;
    int         lat;
    int         steps;
  } vec_t;

  // Reference timing: j = cycles observed since the accepting edge.
  function automatic int exp_lat(input int n);
    return (n == 0) ? 1 : 1 + SETUP + n * PER;
  endfunction

  function automatic logic exp_step(input int n, input int j);
    int idx;
    idx = j - SETUP;
    if (idx < 0 || idx >= n * PER) return 1'b1;
    return (idx % PER) >= LO;
  endfunction

  function automatic int exp_cnt(input int n, input int j);
    int idx, c;
    idx = j - SETUP;
    if (idx < LO) return 0;
    c = (idx - LO) / PER + 1;
    return (c > n) ? n : c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after reset/lock return until rst_out drops; optional 1-cycle lock glitch.
  task automatic wait_release(input int glitch_at, output int c, output int bad);
    c = 0;
    bad = 0;
    do begin
      tick();
      c++;
      if (c == glitch_at) pll_locked = 1'b0;
      if (c == glitch_at + 1) pll_locked = 1'b1;
      if (rst_out && (req_ready || !phasestep || busy)) bad++;
    end while (rst_out && c < 300);
  endtask

  task automatic do_req(input logic [1:0] s, input logic d, input int n,
                        output int lat, output int st, output int ab, output int bad);
    int j;
    bad = 0;
    chk("ready_before_req", int'(req_ready), 1);
    req_sel   = s;
    req_dir   = d;
    req_steps = CNT_W'(n);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    j = 0;
    while (!done && j < 4000) begin
      if (phasestep !== exp_step(n, j)) bad++;
      if (int'(steps_issued) != exp_cnt(n, j)) bad++;
      if (phasesel !== s || phasedir !== d) bad++;
      if (req_ready !== 1'b0) bad++;
      if (busy !== (n > 0)) bad++;
      tick();
      j++;
    end
    lat = j + 1;
    st  = int'(steps_issued);
    ab  = int'(abort);
    if (busy || !phasestep) bad++;
    tick();
    if (phasesel !== s || phasedir !== d || !phasestep) bad++;
  endtask

  initial begin
    vec_t tbl[5];
    int lat, st, ab, bad, c, n, j, nacc, second, tmo;
    logic [1:0] s;
    logic d, a;

    tbl[0] = '{sel: 2'd1, dir: 1'b0, n: 3,   lat: 41,   steps: 3};
    tbl[1] = '{sel: 2'd2, dir: 1'b1, n: 0,   lat: 1,    steps: 0};
    tbl[2] = '{sel: 2'd3, dir: 1'b1, n: 1,   lat: 17,   steps: 1};
    tbl[3] = '{sel: 2'd0, dir: 1'b0, n: 2,   lat: 29,   steps: 2};
    tbl[4] = '{sel: 2'd1, dir: 1'b1, n: 255, lat: 3065, steps: 255};

    repeat (3) tick();
    chk("rst_rst_out", int'(rst_out), 1);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_phasestep", int'(phasestep), 1);
    chk("rst_phasedir", int'(phasedir), 1);
    chk("rst_phasesel", int'(phasesel), 0);
    chk("rst_busy_done_abort", int'({busy, done, abort}), 0);
    chk("rst_steps", int'(steps_issued), 0);
    reset = 1'b0;
    wait_release(0, c, bad);
    chk("release_cycles", c, 2 + LSC);
    chk("lockwait_outputs", bad, 0);
    chk("ready_at_release", int'(req_ready), 1);

    foreach (tbl[i]) begin
      do_req(tbl[i].sel, tbl[i].dir, tbl[i].n, lat, st, ab, bad);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_steps", i), st, tbl[i].steps);
      chk($sformatf("tbl%0d_abort", i), ab, 0);
      chk($sformatf("tbl%0d_trace", i), bad, 0);
    end

    for (int k = 0; k < 8; k++) begin
      s = 2'($urandom_range(0, 3));
      d = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 6);
      repeat ($urandom_range(0, 3)) tick();
      do_req(s, d, n, lat, st, ab, bad);
      chk($sformatf("rnd%0d_lat", k), lat, exp_lat(n));
      chk($sformatf("rnd%0d_steps", k), st, n);
      chk($sformatf("rnd%0d_abort", k), ab, 0);
      chk($sformatf("rnd%0d_trace", k), bad, 0);
    end

    // Valid held high across a running request: one acceptance per IDLE visit.
    req_sel = 2'd2; req_dir = 1'b1; req_steps = CNT_W'(1); req_valid = 1'b1;
    nacc = 0; second = -1;
    for (int k = 0; k < 30; k++) begin
      a = req_valid && req_ready;
      tick();
      if (a) begin
        nacc++;
        if (nacc == 2) second = k;
      end
    end
    req_valid = 1'b0;
    chk("held_valid_accepts", nacc, 2);
    chk("held_valid_second_at", second, exp_lat(1) + 1);
    tmo = 0;
    while (!req_ready && tmo < 100) begin tick(); tmo++; end
    chk("held_valid_back_idle", int'(req_ready), 1);

    // Lock drop during the 2nd PULSE_HI of a 5-step request.
    req_sel = 2'd3; req_dir = 1'b0; req_steps = CNT_W'(5); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    j = 0; bad = 0;
    while (!done && j < 100) begin
      if (j == SETUP + PER + LO) pll_locked = 1'b0;
      if (j > SETUP + PER + LO + 2 && !phasestep) bad++;
      tick();
      j++;
    end
    chk("drop_done_at", j, SETUP + PER + LO + 3);
    chk("drop_abort", int'(abort), 1);
    chk("drop_steps", int'(steps_issued), 2);
    chk("drop_no_pulse", bad, 0);
    chk("drop_rst_out", int'(rst_out), 1);
    pll_locked = 1'b1;
    wait_release(0, c, bad);
    chk("drop_release_cycles", c, 2 + LSC);
    chk("drop_lockwait_outputs", bad, 0);
    do_req(2'd0, 1'b1, 1, lat, st, ab, bad);
    chk("after_drop_lat", lat, exp_lat(1));
    chk("after_drop_trace", bad, 0);

    // Reset in the middle of a low pulse, then a lock glitch at count 10.
    req_sel = 2'd1; req_dir = 1'b0; req_steps = CNT_W'(3); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (SETUP + 1) tick();
    chk("midop_in_pulse", int'(phasestep), 0);
    reset = 1'b1;
    tick();
    chk("midop_phasestep", int'(phasestep), 1);
    chk("midop_busy", int'(busy), 0);
    chk("midop_rst_out", int'(rst_out), 1);
    chk("midop_steps", int'(steps_issued), 0);
    chk("midop_sel_dir", int'({phasesel, phasedir}), 1);
    reset = 1'b0;
    wait_release(10, c, bad);
    chk("glitch_release_cycles", c, 2 + 10 + 1 + LSC);
    chk("glitch_lockwait_outputs", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pll_phase_sequencer.md
Name: pll_phase_sequencer

Overview:
Controller for the ECP5 EHXPLLL dynamic phase-shift port and the lock-qualified reset.
- Accepts phase-shift requests (output select, direction, step count) over a valid/ready handshake.
- Sequences PHASESEL/PHASEDIR/PHASESTEP with the required setup and pulse timing.
- Counts the steps issued, and holds the downstream domain in reset until PLL lock has been stable.
- Sits beside the PLL instance in the board top level. Runs in the reference input-clock domain.

Parameters:
SETUP_CYC, 4, cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP pulse of a request.
STEP_LOW_CYC, 4, cycles PHASESTEP is held low per step.
STEP_GAP_CYC, 8, cycles PHASESTEP is held high between steps and after the last step.
LOCK_STABLE_CYC, 1024, consecutive synchronised-locked cycles required before lock is considered stable.
CNT_W, 8, width of the step count.

Ports:
clock  in  1  reference clock; all logic on rising edge
reset  in  1  synchronous, active-high
pll_locked  in  1  PLL LOCK, asynchronous; double-flop synchronised internally
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready in the same cycle
req_sel  in  2  PLL output select (0=CLKOP,1=CLKOS,2=CLKOS2,3=CLKOS3)
req_dir  in  1  0=lag, 1=lead (driven to PHASEDIR)
req_steps  in  CNT_W  number of phase steps; 0 legal
pll_phasesel  out  2  to PHASESEL1:0
pll_phasedir  out  1  to PHASEDIR
pll_phasestep  out  1  to PHASESTEP; idle high, a step is one low pulse
busy  out  1  high from acceptance until done
done  out  1  one-cycle pulse at request completion
abort  out  1  qualifies done: request ended by lock loss
steps_issued  out  CNT_W  PHASESTEP pulses issued for the last/current request
rst_out  out  1  synchronous active-high reset for downstream logic

Behaviour:
- Reset values:
  - state=LOCK_WAIT; req_ready=0, busy=0, done=0, abort=0, steps_issued=0.
  - pll_phasesel=0, pll_phasedir=1, pll_phasestep=1, rst_out=1.
  - Lock synchroniser flops and stable counter cleared.
- lock_s = pll_locked after two flops (2-cycle latency).
- States:
  - LOCK_WAIT:
    - stable counter increments while lock_s=1 and clears to 0 when lock_s=0.
    - When the count reaches LOCK_STABLE_CYC-1 with lock_s=1, go to IDLE. rst_out deasserts on that transition, so it is 0 in the first IDLE cycle.
    - The counter saturates; it does not wrap.
  - IDLE:
    - req_ready=1.
    - On valid&ready: latch sel/dir/steps, clear steps_issued, busy=1, drive phasesel/phasedir from the latched values.
    - If steps==0, go to DONE; otherwise go to SETUP.
  - SETUP: hold for SETUP_CYC cycles, then go to PULSE_LO.
  - PULSE_LO:
    - phasestep=0 for STEP_LOW_CYC cycles.
    - On exit, steps_issued increments and the remaining count decrements; go to PULSE_HI.
  - PULSE_HI:
    - phasestep=1 for STEP_GAP_CYC cycles.
    - If remaining>0, go to PULSE_LO; otherwise go to DONE.
  - DONE:
    - One cycle: done=1, busy=0; abort as set.
    - Then go to IDLE, or to LOCK_WAIT if lock_s=0.
- req_ready is 0 in every state except IDLE. A request held valid outside IDLE is not consumed.
- phasesel/phasedir are held constant from acceptance through DONE. After DONE they retain their values (no glitching).
- Lock loss (lock_s=0):
  - Any state except LOCK_WAIT: rst_out=1 the next cycle, stable counter cleared.
  - IDLE: go to LOCK_WAIT.
  - SETUP/PULSE_LO/PULSE_HI:
    - phasestep returns to 1 immediately.
    - Go to DONE with abort=1; steps_issued holds the count completed.
    - A PULSE_LO cut short does not count.
    - Then go to LOCK_WAIT.
- Lock loss and a request in the same IDLE cycle: lock loss wins, req_ready=0, request not accepted.
- steps_issued never exceeds req_steps. The maximum request 2^CNT_W-1 completes without wrap.
- Reset asserted mid-operation: all state returns to reset values next cycle; a pulse in progress ends (phasestep=1).
- Request latency with no lock events: done asserts exactly 1+SETUP_CYC+N*(STEP_LOW_CYC+STEP_GAP_CYC) cycles after the accepting edge for N>0, and 1 cycle after for N=0.

Test Plan:
- Reset, pll_locked=1 constant, LOCK_STABLE_CYC=16:
  - rst_out=1 for 2 sync cycles + 16 cycles.
  - rst_out falls with req_ready rising the same cycle.
  - phasestep=1 and phasedir=1 throughout.
- Request sel=1, dir=0, steps=3 (defaults):
  - exactly 3 low pulses of 4 cycles spaced 8 high.
  - phasesel=1 and phasedir=0 stable from acceptance.
  - done at accept+1+4+3*12=+41 with abort=0, steps_issued=3.
- Request steps=0: done 1 cycle after acceptance, no phasestep activity, steps_issued=0.
- pll_locked dropped during 2nd PULSE_HI of a steps=5 request:
  - done with abort=1, steps_issued=2.
  - rst_out=1, req_ready=0 until lock stable again, then normal IDLE.
- req_valid held high through a running request: only one acceptance; second accepted only after DONE returns to IDLE.
- Lock glitch (1 cycle low) inside LOCK_WAIT at count 10: counter restarts; rst_out release delayed by a full LOCK_STABLE_CYC.
